// File: rtl/fft_pkg.sv
// Shared constants and types for the 64-point FFT processor front end.
// Complex words carry the real part in the upper half and the imaginary part in the lower half.
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_POINTS   = 64;
  localparam int ADDR_WIDTH = $clog2(N_POINTS);
  localparam int CPLX_WIDTH = 2 * DATA_WIDTH;

  localparam int REAL_MSB = CPLX_WIDTH - 1;
  localparam int REAL_LSB = DATA_WIDTH;
  localparam int IMAG_MSB = DATA_WIDTH - 1;
  localparam int IMAG_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_CORE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/bitrev_6b_to_6b.sv
// Combinational 6-bit address bit reversal, shared by the input loader and the output reorder logic.
module bitrev_6b_to_6b (
  input  logic [5:0] addr_in,
  output logic [5:0] addr_out
);

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      addr_out[i] = addr_in[5-i];
    end
  end

endmodule

// File: rtl/mux2.sv
// Generic 2:1 multiplexer; in_1 is selected when sel is high.
module mux2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] in_0,
  input  logic [DATA_WIDTH-1:0] in_1,
  output logic [DATA_WIDTH-1:0] out_y
);

  assign out_y = sel ? in_1 : in_0;

endmodule

// File: rtl/fft_input_loader.sv
// Collects one 64-sample frame into the FFT working memory at bit-reversed addresses,
// swapping real/imag for IFFT frames, then pulses Fft_Start once the core is free.
module fft_input_loader #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int N_POINTS   = fft_pkg::N_POINTS,
  parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [2*DATA_WIDTH-1:0] In_Data,
  input  logic                    Swap,
  input  logic                    Fft_Busy,
  output logic                    Wr_En,
  output logic [ADDR_WIDTH-1:0]   Wr_Addr,
  output logic [2*DATA_WIDTH-1:0] Wr_Data,
  output logic                    Fft_Start,
  output logic                    Frame_Swap
);

  localparam int CW = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastCnt = ADDR_WIDTH'(N_POINTS - 1);

  typedef fft_pkg::loader_state_e state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  frame_swap_q, frame_swap_d;
  logic                  armed_q, armed_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]         wr_data_q, wr_data_d;

  logic                  ready;
  logic                  start;
  logic                  sample_swap;
  logic [CW-1:0]         swapped_data;
  logic [CW-1:0]         sel_data;
  logic [ADDR_WIDTH-1:0] rev_addr;

  // Sample 0 must already use the mode it latches, so IDLE takes Swap directly.
  assign sample_swap  = (state_q == fft_pkg::ST_IDLE) ? Swap : frame_swap_q;
  assign swapped_data = {In_Data[DATA_WIDTH-1:0], In_Data[CW-1:DATA_WIDTH]};

  mux2 #(
    .DATA_WIDTH(CW)
  ) u_swap_mux (
    .sel   (sample_swap),
    .in_0  (In_Data),
    .in_1  (swapped_data),
    .out_y (sel_data)
  );

  bitrev_6b_to_6b u_bitrev (
    .addr_in  (cnt_q),
    .addr_out (rev_addr)
  );

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_swap_d = frame_swap_q;
    armed_d      = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    ready        = 1'b0;
    start        = 1'b0;

    case (state_q)
      fft_pkg::ST_IDLE: begin
        ready = 1'b1;
        if (In_Valid) begin
          frame_swap_d = Swap;
          cnt_d        = ADDR_WIDTH'(1);
          state_d      = fft_pkg::ST_LOAD;
        end
      end
      fft_pkg::ST_LOAD: begin
        ready = 1'b1;
        if (In_Valid) begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == LastCnt) begin
            state_d = fft_pkg::ST_WAIT_CORE;
          end
        end
      end
      fft_pkg::ST_WAIT_CORE: begin
        // armed_q is low on the entry cycle so the last write lands before the start pulse.
        armed_d = 1'b1;
        if (armed_q && !Fft_Busy) begin
          start   = 1'b1;
          armed_d = 1'b0;
          state_d = fft_pkg::ST_IDLE;
        end
      end
      default: begin
        state_d = fft_pkg::ST_IDLE;
      end
    endcase

    if (ready && In_Valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rev_addr;
      wr_data_d = sel_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= fft_pkg::ST_IDLE;
      cnt_q        <= '0;
      frame_swap_q <= 1'b0;
      armed_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_swap_q <= frame_swap_d;
      armed_q      <= armed_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign In_Ready   = ready && !Rst;
  assign Fft_Start  = start && !Rst;
  assign Wr_En      = wr_en_q;
  assign Wr_Addr    = wr_addr_q;
  assign Wr_Data    = wr_data_q;
  assign Frame_Swap = frame_swap_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: inputs change 1 time unit after the rising edge,
// outputs are checked on the falling edge of the same cycle.
module tb_fft_input_loader;
  import fft_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Data;
  logic        Swap;
  logic        Fft_Busy;
  logic        Wr_En;
  logic [5:0]  Wr_Addr;
  logic [31:0] Wr_Data;
  logic        Fft_Start;
  logic        Frame_Swap;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  fft_input_loader dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Data    (In_Data),
    .Swap       (Swap),
    .Fft_Busy   (Fft_Busy),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Fft_Start  (Fft_Start),
    .Frame_Swap (Frame_Swap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sample k = {k, -k} as 16-bit two's complement halves.
  function automatic logic [31:0] sample(input int k);
    logic [15:0] re;
    logic [15:0] im;
    re = 16'(k);
    im = 16'(-k);
    return {re, im};
  endfunction

  function automatic logic [31:0] swp(input logic [31:0] x);
    return {x[IMAG_MSB:IMAG_LSB], x[REAL_MSB:REAL_LSB]};
  endfunction

  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      if (((k >> i) & 1) != 0) r |= (1 << (5 - i));
    end
    return r;
  endfunction

  task automatic tick(input logic rst, input logic v, input logic [31:0] d, input logic sw,
                      input logic busy);
    @(posedge Clk);
    #1;
    Rst      = rst;
    In_Valid = v;
    In_Data  = d;
    Swap     = sw;
    Fft_Busy = busy;
    @(negedge Clk);
  endtask

  task automatic observe_write(input string name, input logic pend, input int pk, input logic fs);
    if (Wr_En === 1'b1) wr_count++;
    check($sformatf("%s_wr_en", name), {31'd0, Wr_En}, {31'd0, pend});
    if (pend) begin
      check($sformatf("%s_addr_k%0d", name, pk), {26'd0, Wr_Addr}, 32'(bitrev(pk)));
      check($sformatf("%s_data_k%0d", name, pk), Wr_Data, fs ? swp(sample(pk)) : sample(pk));
    end
  endtask

  // Drives one full frame (optionally with gaps), then follows the turnaround up to the Fft_Start cycle.
  task automatic run_frame(input string name, input logic swap0, input int gap_pct,
                           input int busy_hold, input logic hold_valid, input logic next_swap);
    logic pend;
    int   pk;
    pend     = 1'b0;
    pk       = 0;
    wr_count = 0;
    for (int k = 0; k < N_POINTS; k++) begin
      for (int g = 0; g < 3; g++) begin
        if (gap_pct == 0 || $urandom_range(99, 0) >= gap_pct) break;
        tick(1'b0, 1'b0, $urandom, 1'($urandom_range(1, 0)), 1'b0);
        observe_write(name, pend, pk, swap0);
        pend = 1'b0;
        check($sformatf("%s_gap_ready", name), {31'd0, In_Ready}, 32'd1);
      end
      tick(1'b0, 1'b1, sample(k), (k == 0) ? swap0 : ~swap0, 1'b0);
      observe_write(name, pend, pk, swap0);
      check($sformatf("%s_ready_k%0d", name, k), {31'd0, In_Ready}, 32'd1);
      check($sformatf("%s_nostart_k%0d", name, k), {31'd0, Fft_Start}, 32'd0);
      if (k > 0) check($sformatf("%s_fswap_k%0d", name, k), {31'd0, Frame_Swap}, {31'd0, swap0});
      pend = 1'b1;
      pk   = k;
    end

    tick(1'b0, hold_valid, sample(0), next_swap, busy_hold > 0);
    observe_write(name, pend, pk, swap0);
    check($sformatf("%s_wait_ready", name), {31'd0, In_Ready}, 32'd0);
    check($sformatf("%s_wait_nostart", name), {31'd0, Fft_Start}, 32'd0);

    for (int i = 2; i <= busy_hold; i++) begin
      tick(1'b0, hold_valid, sample(0), next_swap, 1'b1);
      check($sformatf("%s_busy_ready_%0d", name, i), {31'd0, In_Ready}, 32'd0);
      check($sformatf("%s_busy_nostart_%0d", name, i), {31'd0, Fft_Start}, 32'd0);
      check($sformatf("%s_busy_nowr_%0d", name, i), {31'd0, Wr_En}, 32'd0);
    end

    tick(1'b0, hold_valid, sample(0), next_swap, 1'b0);
    check($sformatf("%s_start", name), {31'd0, Fft_Start}, 32'd1);
    check($sformatf("%s_start_ready", name), {31'd0, In_Ready}, 32'd0);
    check($sformatf("%s_start_nowr", name), {31'd0, Wr_En}, 32'd0);
    check($sformatf("%s_start_fswap", name), {31'd0, Frame_Swap}, {31'd0, swap0});
    check($sformatf("%s_write_count", name), 32'(wr_count), 32'(N_POINTS));
  endtask

  task automatic idle_check(input string name, input logic fs);
    tick(1'b0, 1'b0, 32'd0, ~fs, 1'b0);
    check($sformatf("%s_idle_nostart", name), {31'd0, Fft_Start}, 32'd0);
    check($sformatf("%s_idle_ready", name), {31'd0, In_Ready}, 32'd1);
    check($sformatf("%s_idle_nowr", name), {31'd0, Wr_En}, 32'd0);
    check($sformatf("%s_idle_fswap", name), {31'd0, Frame_Swap}, {31'd0, fs});
  endtask

  initial begin
    logic pend;
    int   pk;
    Rst      = 1'b1;
    In_Valid = 1'b0;
    In_Data  = 32'd0;
    Swap     = 1'b0;
    Fft_Busy = 1'b0;

    // Reset cycle and reset values.
    tick(1'b1, 1'b1, sample(5), 1'b1, 1'b0);
    check("rst_cycle_ready", {31'd0, In_Ready}, 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("rst_ready", {31'd0, In_Ready}, 32'd1);
    check("rst_wr_en", {31'd0, Wr_En}, 32'd0);
    check("rst_wr_addr", {26'd0, Wr_Addr}, 32'd0);
    check("rst_wr_data", Wr_Data, 32'd0);
    check("rst_start", {31'd0, Fft_Start}, 32'd0);
    check("rst_fswap", {31'd0, Frame_Swap}, 32'd0);

    // Hand-computed bit-reversal anchors.
    check("bitrev_1", 32'(bitrev(1)), 32'd32);
    check("bitrev_2", 32'(bitrev(2)), 32'd16);

    // Forward frame, no gaps, core idle: start two cycles after the last accept.
    run_frame("fwd", 1'b0, 0, 0, 1'b0, 1'b0);
    idle_check("fwd", 1'b0);

    // IFFT frame: mode taken from sample 0 only, held through idle.
    run_frame("ifft", 1'b1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_check("ifft", 1'b1);

    // Random gaps plus 20 busy cycles after the last accept.
    run_frame("gap", 1'b0, 30, 20, 1'b1, 1'b0);
    idle_check("gap", 1'b0);

    // Reset after 30 accepts of an IFFT frame.
    pend     = 1'b0;
    pk       = 0;
    wr_count = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b1, sample(k), (k == 0), 1'b0);
      observe_write("part", pend, pk, 1'b1);
      pend = 1'b1;
      pk   = k;
    end
    tick(1'b1, 1'b1, sample(30), 1'b1, 1'b0);
    observe_write("part", pend, pk, 1'b1);
    check("part_rst_ready", {31'd0, In_Ready}, 32'd0);
    check("part_rst_nostart", {31'd0, Fft_Start}, 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("part_after_wr_en", {31'd0, Wr_En}, 32'd0);
    check("part_after_addr", {26'd0, Wr_Addr}, 32'd0);
    check("part_after_data", Wr_Data, 32'd0);
    check("part_after_fswap", {31'd0, Frame_Swap}, 32'd0);
    check("part_after_ready", {31'd0, In_Ready}, 32'd1);
    for (int i = 0; i < 4; i++) idle_check("part", 1'b0);
    run_frame("post_rst", 1'b0, 0, 0, 1'b0, 1'b0);
    idle_check("post_rst", 1'b0);

    // Back-to-back: In_Valid held through the turnaround; second frame is IFFT.
    run_frame("b2b_a", 1'b0, 0, 0, 1'b1, 1'b1);
    run_frame("b2b_b", 1'b1, 0, 0, 1'b0, 1'b0);
    idle_check("b2b_b", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Input-side frame loader for the 64-point FFT processor, the front-end counterpart of the output scaling stage. Accepts complex samples over a valid/ready stream and swaps real/imag in IFFT mode, so the same forward core computes an inverse transform. Writes each sample into the core's working memory at its bit-reversed address and issues a one-cycle start once a full 64-sample frame is stored. Latches the frame's mode and presents it on `Frame_Swap`; the output scaling stage uses it as its `Swap` select to apply the matching swap and 1/64 scaling.

## Interface
- `DATA_WIDTH`, 16, width of each real/imag component (two's complement)
- `N_POINTS`, 64, samples per frame (power of two)
- `ADDR_WIDTH`, 6, log2(`N_POINTS`)

- `Clk`  in  1  sole clock, rising edge
- `Rst`  in  1  synchronous, active-high reset
- `In_Valid`  in  1  upstream sample valid
- `In_Ready`  out  1  loader can accept a sample this cycle
- `In_Data`  in  2*DATA_WIDTH  sample; [31:16] real, [15:0] imag
- `Swap`  in  1  IFFT mode request; sampled only on a frame's first accepted sample
- `Fft_Busy`  in  1  core is computing and must not be started
- `Wr_En`  out  1  memory write strobe
- `Wr_Addr`  out  ADDR_WIDTH  bit-reversed write address
- `Wr_Data`  out  2*DATA_WIDTH  sample to store, swapped if IFFT mode
- `Fft_Start`  out  1  one-cycle pulse: frame complete, core may begin
- `Frame_Swap`  out  1  latched mode of the current or last frame; drives output-stage `Swap`

## Operation
- Accept condition: `In_Valid && In_Ready` on a rising edge.
- Counter `cnt` is ADDR_WIDTH bits and counts accepted samples in the frame.
- States:
  - IDLE: `In_Ready`=1. On accept, latch `Frame_Swap`←`Swap`, write the sample, `cnt`←1, go to LOAD.
  - LOAD: `In_Ready`=1. Each accept writes one sample and increments `cnt`. The accept with `cnt`=N_POINTS−1 goes to WAIT_CORE. `In_Valid` gaps are allowed and hold state.
  - WAIT_CORE: `In_Ready`=0. On the first cycle with `Fft_Busy`=0 (evaluated no earlier than the cycle after entry), pulse `Fft_Start` for one cycle and go to IDLE.
- Write address: the bit-reverse of `cnt` before increment. Sample k goes to bitrev6(k): k=1→32, k=2→16, k=63→63.
- Write data:
  - `Frame_Swap`=0: unchanged.
  - `Frame_Swap`=1: {imag, real}.
  - No arithmetic and no width change; scaling is done only at the output stage.
- The mode used for a sample's swap is the latched `Frame_Swap`, including for sample 0.
- Changes on `Swap` mid-frame are ignored.
- `Frame_Swap` holds its value through IDLE until the next frame's first accept.
- `In_Data` and `Swap` are don't-care when `In_Valid`=0.

## Timing
- Reset values: `In_Ready`=0 during the `Rst` cycle and 1 the cycle after. `Wr_En`=0, `Wr_Addr`=0, `Wr_Data`=0, `Fft_Start`=0, `Frame_Swap`=0, state IDLE, `cnt`=0.
- Write path is registered: an accept at edge t gives `Wr_En`/`Wr_Addr`/`Wr_Data` valid in the cycle after t, for exactly one cycle per accept.
- Last accept at edge t:
  - its write appears in cycle t+1;
  - `Fft_Start` appears in cycle t+2 at the earliest, so the write always precedes start.
- `Fft_Busy` held high delays `Fft_Start` indefinitely. No samples are accepted meanwhile.
- The first accept of the next frame is possible the cycle after `Fft_Start`.
- `Rst` mid-frame or in WAIT_CORE:
  - the partial frame is discarded; no `Fft_Start`;
  - a write registered in the reset cycle is suppressed (`Wr_En`=0 next cycle).
- Peak throughput: one sample per cycle, i.e. 64 cycles per frame plus at least 2 cycles of turnaround.

## Structure
- Shared package `fft_pkg`: `N_POINTS`, `ADDR_WIDTH`, `DATA_WIDTH`, state encoding (IDLE, LOAD, WAIT_CORE), complex-word field positions.
- Sub-module `bitrev_6b_to_6b`: combinational address reversal, reusable by the output reorder logic.
- Swap mux: reuse the existing 2:1 mux with DATA_WIDTH=32.

## Test plan
- Forward frame, no gaps: `Swap`=0, sample k = {k, −k}. Expect 64 writes with `Wr_Addr`=bitrev(k) and `Wr_Data`={k, −k}; `Fft_Start` exactly 2 cycles after the last accept; `Frame_Swap`=0.
- IFFT frame: `Swap`=1 on sample 0, then `Swap`=0 for the rest. Expect every `Wr_Data`={−k, k} and `Frame_Swap`=1 held after the frame.
- Gaps and backpressure: randomly drop `In_Valid`, and hold `Fft_Busy`=1 for 20 cycles after the last accept. Expect `In_Ready`=0 throughout WAIT_CORE, `Fft_Start` the first cycle after `Fft_Busy` falls, and still exactly 64 writes.
- Reset mid-frame: assert `Rst` after 30 accepts, then send a full frame. Expect no `Fft_Start` for the partial frame and the new frame's first write at address 0.
- Back-to-back frames: present `In_Valid` continuously for 128 samples. Expect the second frame's first accept the cycle after `Fft_Start`, with `Frame_Swap` updated from `Swap` at that accept.
- Reset values: check every output right after `Rst` deasserts; `In_Ready` must be 0 during the `Rst` cycle.
